// File: rtl/gray_display_controller.sv
// rtl/gray_display_controller.sv - debounced Gray switch input to binary LED and muxed 7-segment display
module gray_display_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REFRESH_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ag,
  input  logic       bg,
  input  logic       cg,
  input  logic       dg,
  output logic [3:0] led,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       update
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

  state_t          state, state_n;
  logic [3:0]      sync1, sync2;
  logic [3:0]      cand, committed;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   rcnt, rcnt_n;
  logic            digit_sel, digit_sel_n;
  logic            tens;
  logic [3:0]      units;

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  // Two-flop synchronizer for the asynchronous switches
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= {ag, bg, cg, dg};
      sync2 <= sync1;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Debounce FSM next-state: a new value must hold DEBOUNCE_CYCLES checks before commit
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sync2 != committed) state_n = CHECK;
      CHECK: begin
        if (sync2 != cand)         state_n = IDLE;
        else if (cnt == CNT_LAST)  state_n = COMMIT;
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Candidate capture, hold counter and commit of the new value to led
  always_ff @(posedge clk) begin
    if (rst) begin
      cand      <= 4'b0000;
      cnt       <= '0;
      committed <= 4'b0000;
      led       <= 4'b0000;
      update    <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2 != committed) begin
            cand <= sync2;
            cnt  <= '0;
          end
        end
        CHECK: begin
          if (sync2 == cand && cnt != CNT_LAST) cnt <= cnt + CW'(1);
        end
        COMMIT: begin
          committed <= cand;
          led       <= gray2bin(cand);
          update    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Decimal split of the displayed value and next scan position
  always_comb begin
    tens        = (led >= 4'd10);
    units       = tens ? (led - 4'd10) : led;
    rcnt_n      = (rcnt == RCNT_LAST) ? '0 : rcnt + RW'(1);
    digit_sel_n = (rcnt == RCNT_LAST) ? ~digit_sel : digit_sel;
  end

  // Free-running scan: blank on slot 0, then drive the selected digit
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt      <= '0;
      digit_sel <= 1'b0;
      an        <= 2'b00;
      seg       <= 7'b0000000;
    end else begin
      rcnt      <= rcnt_n;
      digit_sel <= digit_sel_n;
      if (rcnt_n == '0) begin
        an  <= 2'b00;
        seg <= 7'b0000000;
      end else if (digit_sel_n) begin
        an  <= 2'b10;
        seg <= tens ? digit_pattern(4'd1) : 7'b0000000;
      end else begin
        an  <= 2'b01;
        seg <= digit_pattern(units);
      end
    end
  end

endmodule

// File: tb/tb_gray_display_controller.sv
// tb/tb_gray_display_controller.sv - self-checking bench for gray_display_controller
module tb_gray_display_controller;

  localparam int D = 4;
  localparam int R = 8;

  logic       clk;
  logic       rst;
  logic [3:0] g;
  logic [3:0] led;
  logic [6:0] seg;
  logic [1:0] an;
  logic       update;

  int vectors     = 0;
  int miscompares = 0;
  logic chk_en    = 1'b0;

  gray_display_controller #(.DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut (
    .clk    (clk),
    .rst    (rst),
    .ag     (g[3]),
    .bg     (g[2]),
    .cg     (g[1]),
    .dg     (g[0]),
    .led    (led),
    .seg    (seg),
    .an     (an),
    .update (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reference model: behaviour from the rules, tracked by timestamps
  function automatic logic [3:0] m_g2b(input logic [3:0] x);
    return x ^ (x >> 1) ^ (x >> 2) ^ (x >> 3);
  endfunction

  function automatic logic [6:0] m_pat(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    return tbl[d];
  endfunction

  logic [3:0] ms1, ms2, mcomm, mcand, mled, pled;
  logic       mupd;
  logic [1:0] man;
  logic [6:0] mseg;
  int         mode, ts, t, n, r, uval;

  always @(posedge clk) begin
    t++;
    if (rst) begin
      ms1 = 0; ms2 = 0; mcomm = 0; mcand = 0; mled = 0;
      mupd = 0; man = 0; mseg = 0; mode = 0; n = 0;
    end else begin
      pled = mled;
      mupd = 0;
      if (mode == 0) begin
        if (ms2 != mcomm) begin mcand = ms2; ts = t; mode = 1; end
      end else if (mode == 1) begin
        if (ms2 != mcand)     mode = 0;
        else if (t - ts == D) mode = 2;
      end else begin
        mcomm = mcand; mled = m_g2b(mcand); mupd = 1; mode = 0;
      end
      n++;
      r = n % (2 * R);
      uval = (pled >= 10) ? int'(pled) - 10 : int'(pled);
      if (r == 0 || r == R) begin man = 2'b00; mseg = 7'b0; end
      else if (r < R)       begin man = 2'b01; mseg = m_pat(uval); end
      else begin man = 2'b10; mseg = (pled >= 10) ? 7'b0110000 : 7'b0; end
      ms2 = ms1;
      ms1 = g;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_led", led, mled);
      check("cyc_update", update, mupd);
      check("cyc_an", an, man);
      check("cyc_seg", seg, mseg);
    end
  end

  task automatic wait_update(input string name);
    int c;
    bit found;
    c = 0; found = 0;
    while (!found && c < 20) begin
      @(negedge clk);
      c++;
      if (update === 1'b1) found = 1;
    end
    check(name, c - 1, 7);
  endtask

  task automatic scan_seg(input string nu, input logic [6:0] eu, input string nt, input logic [6:0] et);
    bit su, st;
    su = 0; st = 0;
    tick(1);
    for (int i = 0; i < 2 * R + 2 && !(su && st); i++) begin
      @(negedge clk);
      if (!su && an === 2'b01) begin check(nu, seg, eu); su = 1; end
      if (!st && an === 2'b10) begin check(nt, seg, et); st = 1; end
    end
    if (!su) check({nu, "_seen"}, 0, 1);
    if (!st) check({nt, "_seen"}, 0, 1);
  endtask

  initial begin
    int nupd, c00, c01, c10, rep;
    logic [1:0] hist [32];
    t = 0;
    g = 4'b0000;
    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    check("rst_led", led, 4'b0000);
    check("rst_update", update, 1'b0);
    check("rst_an", an, 2'b00);
    rst = 1'b0;
    tick(1);
    check("t1_an_units", an, 2'b01);
    check("t1_seg_units", seg, 7'b1111110);
    tick(10);
    check("t1_an_tens", an, 2'b10);
    check("t1_seg_tens", seg, 7'b0000000);

    g = 4'b1000;
    wait_update("t2_latency");
    check("t2_led", led, 4'b1111);
    scan_seg("t2_units", 7'b1011011, "t2_tens", 7'b0110000);

    g = 4'b0011;
    tick(12);
    check("t3_led_2", led, 4'b0010);
    scan_seg("t3_units_2", 7'b1101101, "t3_tens_blank", 7'b0000000);
    g = 4'b1100;
    tick(12);
    check("t3_led_8", led, 4'b1000);
    scan_seg("t3_units_8", 7'b1111111, "t3_tens_8", 7'b0000000);

    g = 4'b0000;
    tick(12);
    check("t4_led_pre", led, 4'b0000);
    nupd = 0;
    g = 4'b0001;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (update === 1'b1) nupd++; end
    g = 4'b0000;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (update === 1'b1) nupd++; end
    check("t4_bounce_updates", nupd, 0);
    check("t4_led", led, 4'b0000);

    for (int i = 0; i < 32; i++) begin @(negedge clk); hist[i] = an; end
    c00 = 0; c01 = 0; c10 = 0; rep = 0;
    for (int i = 0; i < 16; i++) begin
      if (hist[i] == 2'b00) c00++;
      if (hist[i] == 2'b01) c01++;
      if (hist[i] == 2'b10) c10++;
      if (hist[i] != hist[i + 16]) rep++;
    end
    check("t5_blank_slots", c00, 2);
    check("t5_units_slots", c01, 7);
    check("t5_tens_slots", c10, 7);
    check("t5_period16", rep, 0);

    g = 4'b1100;
    tick(12);
    check("t6_led_pre", led, 4'b1000);
    g = 4'b0101;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("t6_rst_led", led, 4'b0000);
    check("t6_rst_update", update, 1'b0);
    check("t6_rst_an", an, 2'b00);
    rst = 1'b0;
    wait_update("t6_latency");
    check("t6_led", led, 4'b0110);
    tick(4);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

endmodule
